// File: rtl/io_pkg.sv
// Shared I/O definitions for the serial capture and output serializer stages:
// block/digit/key widths and the two-state transfer FSM encoding.
package io_pkg;

  localparam int DIGIT_W    = 4;
  localparam int BLOCK_W    = 32;
  localparam int KEY_W      = 64;
  localparam int NUM_DIGITS = BLOCK_W / DIGIT_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/output_serializer.sv
// output_serializer: streams one W-bit block as W/M digits of M bits,
// most significant digit first, over a valid/ready output handshake.
// Optional feature macro OUTPUT_SERIALIZER_PARITY_EN adds the dout_par
// output (even parity of the current digit while it is valid).
//
// Handshake: a digit transfers on every rising edge where dout_valid and
// dout_ready are both high. While dout_valid is high and dout_ready is low,
// dout holds its value. dout_valid never drops without a transfer except
// on reset. dout_ready is ignored while dout_valid is low.
module output_serializer
  import io_pkg::*;
#(
  parameter int W = BLOCK_W,
  parameter int M = DIGIT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] data_in,
  input  logic         load,
  output logic         busy,
  output logic [M-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         done,
`ifdef OUTPUT_SERIALIZER_PARITY_EN
  output logic         dout_par,
`endif
  output logic         dbg_state
);

  localparam int NUM = W / M;
  localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM - 1);

  ser_state_t   state_q, state_d;
  logic [W-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0] dout_q, dout_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // Next-state logic: load in IDLE, shift one digit per handshake in SEND.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SEND;
          shreg_d = data_in;
          cnt_d   = '0;
          dout_d  = data_in[W-1 -: M];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        if (valid_q && dout_ready) begin
          shreg_d = shreg_q << M;
          if (cnt_q == LAST_CNT) begin
            // Last digit accepted: leave with a one-cycle done pulse.
            state_d = IDLE;
            cnt_d   = '0;
            dout_d  = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d  = cnt_q + CW'(1);
            dout_d = shreg_d[W-1 -: M];
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

`ifdef OUTPUT_SERIALIZER_PARITY_EN
  // Parity follows the registered digit and is forced low when idle.
  assign dout_par = valid_q & (^dout_q);
`endif

endmodule
